case_9_sdiv_10s_10s_10_seq: RTL and testbench
=============================================

Name: case_9_sdiv_10s_10s_10_seq

Overview:
- Multi-cycle signed integer divider; the inverse of the 10s x 10s -> 10 truncating multiplier core.
- Computes C-semantics truncating quotient and remainder of two signed W-bit operands.
- Uses a restoring shift-subtract loop, one quotient bit per cycle.
- Sits beside the multiplier as an HLS-style functional unit, driven by the generated FSM through a start/done handshake with clock enable.

Parameters:
- ID, 1, instance identifier; no functional effect.
- W, 10, operand and result width in bits (signed two's complement); legal range 2..32.

Ports:
- ap_clk  in  1  single clock; all state updates on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- ce  in  1  clock enable; when 0, all registers hold (reset still applies).
- start  in  1  request; sampled only in IDLE with ce=1.
- dividend  in  W  signed numerator; sampled with start.
- divisor  in  W  signed denominator; sampled with start.
- busy  out  1  high in CALC and FIN states.
- done  out  1  one-cycle pulse when results are valid.
- quotient  out  W  signed quotient; held until next done.
- remainder  out  W  signed remainder; held until next done.

Behaviour:
- Reset (ap_rst_n=0 at an edge, regardless of ce):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0.
  - Internal working registers cleared.
  - An in-flight operation is abandoned with no done.
- Gating: every transition below requires ce=1. With ce=0, state, counter, working registers and outputs all hold. done also holds, so a done=1 cycle is stretched while ce=0.
- IDLE:
  - start=1: latch |dividend| and |divisor| as W-bit unsigned magnitudes (|-2^(W-1)| = 2^(W-1), no overflow).
  - Also latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clear partial remainder (W+1 bits); set iteration counter = W; go to CALC.
  - done is cleared to 0 on any enabled edge in IDLE.
- CALC, each enabled edge:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Decrement the counter; when it reaches 0 after this step, go to FIN.
  - Exactly W CALC edges occur.
- FIN, one edge:
  - quotient = sign_q ? -q_mag : q_mag, truncated to W bits.
  - remainder = sign_r ? -r_mag : r_mag, truncated to W bits.
  - done=1; go to IDLE.
- Latency: start high at enabled edge N gives done=1 in the cycle following edge N+W+1 (W=10: 12 cycles, start edge to done visible). Throughput is one operation per W+2 enabled cycles.
- Back-to-back: in the done=1 cycle the state is already IDLE, so start in that cycle is accepted. done drops at the next enabled edge and busy rises. quotient/remainder keep their previous values until the new FIN.
- start while busy=1 is ignored with no queuing; operands presented then are discarded.
- Arithmetic invariant: dividend == quotient*divisor + remainder, mod 2^W. |remainder| < |divisor| and remainder takes the dividend's sign (or is 0).
- Overflow: -2^(W-1) / -1 gives quotient -2^(W-1) (wraps, matching the multiplier's truncation) and remainder 0.
- Divide by zero: produces no error and takes normal latency.
  - Magnitude loop yields q_mag = all ones and r_mag = |dividend|.
  - Final result: quotient = sign_q ? 1 : -1; remainder = dividend.
  - Example (W=10): 37/0 gives q=-1, r=37; -37/0 gives q=1, r=-37.
- Operand inputs are don't-care except in the start-accept cycle.

Test Plan:
- Reset then idle: hold ap_rst_n=0 two edges, release -> busy=0, done=0, quotient=0, remainder=0; no done without start.
- Sign matrix, W=10, ce=1: each op done exactly 12 cycles after start.
  - 100/7 -> 14,2
  - -100/7 -> -14,-2
  - 100/-7 -> -14,2
  - -100/-7 -> 14,-2
- Extremes: -512/-1 -> -512,0; -512/1 -> -512,0; 511/-512 -> 0,511; 37/0 -> -1,37; -37/0 -> 1,-37.
- Handshake: second start with 50/3 pulsed at cycle 5 of an op -> ignored; start on the done cycle with 50/3 -> accepted, next done 12 cycles later with 16,2; first result held meanwhile.
- ce stall: drop ce for 4 cycles mid-CALC -> done delayed by exactly 4 cycles, result unchanged; ce low during done -> done stays high.
- Reset mid-operation: assert ap_rst_n=0 at CALC cycle 6 -> outputs 0, no done. A fresh start 81/9 then completes normally -> 9,0.

Source files
------------

// File: rtl/case_9_sdiv_10s_10s_10_seq.sv
// Multi-cycle signed divider: truncating (C-style) quotient and remainder of
// two W-bit two's-complement operands, one quotient bit per enabled cycle
// using a restoring shift-subtract loop on operand magnitudes.
//
// State table:
//   IDLE | waiting for start; done clears on any enabled edge here
//   CALC | W shift-subtract iterations on the magnitudes
//   FIN  | apply signs, load quotient/remainder, pulse done
//
// Ports:
//   ap_clk     in  clock, all state updates on the rising edge
//   ap_rst_n   in  synchronous active-low reset (independent of ce)
//   ce         in  clock enable; every register holds while low
//   start      in  operation request, sampled only in IDLE
//   dividend   in  W-bit signed numerator, sampled with start
//   divisor    in  W-bit signed denominator, sampled with start
//   busy       out high in CALC and FIN
//   done       out result-valid pulse (stretched while ce is low)
//   quotient   out W-bit signed quotient, held until the next done
//   remainder  out W-bit signed remainder, held until the next done
module case_9_sdiv_10s_10s_10_seq #(
    parameter int ID = 1,
    parameter int W  = 10
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         ce,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  a_mag;     // dividend magnitude, becomes q_mag as bits shift in
    logic [W-1:0]  b_mag;
    logic [W:0]    r_part;
    logic [CW-1:0] cnt;
    logic          sign_q;
    logic          sign_r;

    logic [W-1:0]  dvd_abs;
    logic [W-1:0]  dvs_abs;
    logic [W:0]    shifted;
    logic [W+1:0]  trial;
    logic          trial_ok;

    // Magnitude of the most negative value is 2^(W-1), which still fits
    // in W unsigned bits, so no overflow handling is needed here.
    always_comb begin
        dvd_abs  = dividend[W-1] ? (~dividend + 1'b1) : dividend;
        dvs_abs  = divisor[W-1]  ? (~divisor  + 1'b1) : divisor;
        shifted  = {r_part[W-1:0], a_mag[W-1]};
        trial    = {1'b0, shifted} - {2'b00, b_mag};
        // r_part[W] never sets for in-range magnitudes; if it did, the true
        // shifted value would exceed the divisor, so the subtract is taken.
        trial_ok = r_part[W] | ~trial[W+1];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CW'(1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            a_mag     <= '0;
            b_mag     <= '0;
            r_part    <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (ce) begin
            state <= state_next;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_mag  <= dvd_abs;
                        b_mag  <= dvs_abs;
                        sign_q <= dividend[W-1] ^ divisor[W-1];
                        sign_r <= dividend[W-1];
                        r_part <= '0;
                        cnt    <= CW'(W);
                    end
                end
                CALC: begin
                    if (trial_ok) begin
                        r_part <= trial[W:0];
                        a_mag  <= {a_mag[W-2:0], 1'b1};
                    end else begin
                        r_part <= shifted;
                        a_mag  <= {a_mag[W-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                FIN: begin
                    // -512 / -1 wraps to -512 here, matching the multiplier.
                    quotient  <= sign_q ? (~a_mag + 1'b1) : a_mag;
                    remainder <= sign_r ? (~r_part[W-1:0] + 1'b1) : r_part[W-1:0];
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_case_9_sdiv_10s_10s_10_seq.sv
// Scoreboard bench for the sequential signed divider. The driver pushes the
// hand-computed result and the edge at which done must rise; a monitor pops
// and compares whenever done rises.
module tb_case_9_sdiv_10s_10s_10_seq;

    localparam int W = 10;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n;
    logic         ce;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           cyc;
        string        nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    case_9_sdiv_10s_10s_10_seq #(.ID(1), .W(W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ce        (ce),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // Monitor
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(posedge ap_clk);
            #1;
            if (done && !done_prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done t=%0d q=%0d r=%0d", cyc,
                             $signed(quotient), $signed(remainder));
                end else begin
                    e = sb.pop_front();
                    if (quotient !== e.q || remainder !== e.r || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s got q=%0d r=%0d edge=%0d expected q=%0d r=%0d edge=%0d",
                                 e.nm, $signed(quotient), $signed(remainder), cyc,
                                 $signed(e.q), $signed(e.r), e.cyc);
                    end
                end
            end
            done_prev = done;
        end
    end

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    // Present one start pulse; returns at the negedge after the accept edge.
    task automatic issue(input int a, input int b, input int qe, input int re,
                         input int extra, input bit expect_res, input string nm);
        exp_t e;
        @(negedge ap_clk);
        start    = 1'b1;
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        @(posedge ap_clk);
        #1;
        if (expect_res) begin
            e.q   = qe[W-1:0];
            e.r   = re[W-1:0];
            e.cyc = cyc + W + 1 + extra;
            e.nm  = nm;
            sb.push_back(e);
        end
        @(negedge ap_clk);
        start    = 1'b0;
        dividend = 10'h155;
        divisor  = 10'h2aa;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge ap_clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge ap_clk);
            #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_no_done got 0 expected 1", nm);
        end
    endtask

    int va[9] = '{100, -100, 100, -100, -512, -512, 511, 37, -37};
    int vb[9] = '{7, 7, -7, -7, -1, 1, -512, 0, 0};
    int vq[9] = '{14, -14, -14, 14, -512, -512, 0, -1, 1};
    int vr[9] = '{2, -2, 2, -2, 0, 0, 511, 37, -37};

    initial begin
        ap_rst_n = 1'b0;
        ce       = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        check("rst_busy", {9'b0, busy}, 10'd0);
        check("rst_done", {9'b0, done}, 10'd0);
        check("rst_q", quotient, 10'd0);
        check("rst_r", remainder, 10'd0);
        repeat (5) @(posedge ap_clk);
        #1;
        check("idle_busy", {9'b0, busy}, 10'd0);

        // sign matrix and extremes
        for (int i = 0; i < 9; i++) begin
            issue(va[i], vb[i], vq[i], vr[i], 0, 1'b1, $sformatf("vec%0d", i));
            wait_drain($sformatf("vec%0d", i));
        end

        // start while busy is ignored
        issue(-100, -7, 14, -2, 0, 1'b1, "ignore");
        repeat (3) @(negedge ap_clk);
        start    = 1'b1;
        dividend = 10'd50;
        divisor  = 10'd3;
        @(negedge ap_clk);
        start    = 1'b0;
        wait_drain("ignore");

        // back-to-back: start accepted in the done cycle
        issue(100, 7, 14, 2, 0, 1'b1, "b2b_a");
        wait_done("b2b_a");
        issue(50, 3, 16, 2, 0, 1'b1, "b2b_b");
        check("b2b_busy", {9'b0, busy}, 10'd1);
        check("b2b_done_drop", {9'b0, done}, 10'd0);
        repeat (5) @(posedge ap_clk);
        #1;
        check("b2b_hold_q", quotient, 10'd14);
        check("b2b_hold_r", remainder, 10'd2);
        wait_drain("b2b_b");

        // ce stall of 4 edges mid-CALC
        issue(-100, 7, -14, -2, 4, 1'b1, "stall");
        repeat (2) @(negedge ap_clk);
        ce = 1'b0;
        repeat (4) @(negedge ap_clk);
        ce = 1'b1;
        wait_drain("stall");

        // ce low while done is high stretches done
        issue(-50, 3, -16, -2, 0, 1'b1, "ce_done");
        wait_done("ce_done");
        @(negedge ap_clk);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge ap_clk);
            #1;
            check("ce_done_hold", {9'b0, done}, 10'd1);
        end
        @(negedge ap_clk);
        ce = 1'b1;
        @(posedge ap_clk);
        #1;
        check("ce_done_drop", {9'b0, done}, 10'd0);
        wait_drain("ce_done");

        // reset mid-operation abandons the op
        issue(100, 7, 0, 0, 0, 1'b0, "abort");
        repeat (5) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        check("abort_busy", {9'b0, busy}, 10'd0);
        check("abort_done", {9'b0, done}, 10'd0);
        check("abort_q", quotient, 10'd0);
        check("abort_r", remainder, 10'd0);
        repeat (15) @(posedge ap_clk);
        issue(81, 9, 9, 0, 0, 1'b1, "after_abort");
        wait_drain("after_abort");

        repeat (3) @(posedge ap_clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
